// File: rtl/sal_axi_rd_resp.sv
// sal_axi_rd_resp: AXI3 read-channel target. Queues AR bursts, splits each one
// into in-order backend beat requests, buffers the returned data and emits R
// beats with RID/RRESP/RLAST under RREADY backpressure.
// Optional feature macro: SAL_AXI_RD_RESP_ERR_EN (SLVERR on reserved burst type
// or oversize arsize; when undefined rresp is always OKAY).
module sal_axi_rd_resp #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int AR_DEPTH  = 4,
  parameter int RDB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast
);

  localparam logic [2:0] MAX_SZ = 3'($clog2(DATA_W / 8));
  localparam int AR_AW = $clog2(AR_DEPTH);
  localparam int RD_AW = $clog2(RDB_DEPTH);
  localparam int AR_W  = ID_W + ADDR_W + 4 + 3 + 2;
  localparam int TAG_W = ID_W + 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  // AR queue
  logic [AR_W-1:0] ar_mem [AR_DEPTH];
  logic [AR_AW:0]  ar_wr, ar_rd;
  logic            ar_full, ar_empty, ar_push, ar_pop;

  assign ar_empty = (ar_wr == ar_rd);
  assign ar_full  = (ar_wr[AR_AW] != ar_rd[AR_AW]) &&
                    (ar_wr[AR_AW-1:0] == ar_rd[AR_AW-1:0]);
  assign arready  = !rst && !ar_full;
  assign ar_push  = arvalid && arready;

  // AR queue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_wr <= '0;
      ar_rd <= '0;
    end else begin
      if (ar_push) ar_wr <= ar_wr + 1'b1;
      if (ar_pop)  ar_rd <= ar_rd + 1'b1;
    end
  end

  // AR queue storage
  always_ff @(posedge clk) begin
    if (ar_push) ar_mem[ar_wr[AR_AW-1:0]] <= {arid, araddr, arlen, arsize, arburst};
  end

  // Head-of-queue decode into the effective burst actually executed
  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr, h_total, h_lower;
  logic [3:0]        h_len;
  logic [2:0]        h_size, eff_size;
  logic [1:0]        h_burst, eff_burst;
  logic              h_err;

  assign {h_id, h_addr, h_len, h_size, h_burst} = ar_mem[ar_rd[AR_AW-1:0]];

  // Resolve error / clamping rules and the wrap window of the head burst
  always_comb begin
    h_err     = 1'b0;
    eff_size  = h_size;
    eff_burst = h_burst;
`ifdef SAL_AXI_RD_RESP_ERR_EN
    if (h_burst == BURST_RSVD || h_size > MAX_SZ) begin
      h_err     = 1'b1;
      eff_size  = MAX_SZ;
      eff_burst = BURST_INCR;
    end
`else
    if (h_size > MAX_SZ) eff_size = MAX_SZ;
    if (h_burst == BURST_RSVD) eff_burst = BURST_INCR;
`endif
    if (eff_burst == BURST_WRAP && !(h_len inside {4'd1, 4'd3, 4'd7, 4'd15}))
      eff_burst = BURST_INCR;
    h_total = (ADDR_W'(h_len) + 1'b1) << eff_size;
    h_lower = h_addr & ~(h_total - 1'b1);
  end

  // Active burst context
  logic [ID_W-1:0]   b_id;
  logic [ADDR_W-1:0] b_addr, b_lower, b_upper, b_next, b_incr;
  logic [3:0]        b_cnt;
  logic [2:0]        b_size;
  logic [1:0]        b_burst;
  logic              b_err, req_fire, b_last;

  assign b_incr = b_addr + (ADDR_W'(1) << b_size);
  assign b_last = (b_cnt == 4'd0);

  // Next beat address per burst type
  always_comb begin
    b_next = b_incr;
    if (b_burst == BURST_FIXED) b_next = b_addr;
    else if (b_burst == BURST_WRAP && b_incr == b_upper) b_next = b_lower;
  end

  // Load on pop, advance on each accepted backend request
  always_ff @(posedge clk) begin
    if (ar_pop) begin
      b_id    <= h_id;
      b_addr  <= h_addr;
      b_cnt   <= h_len;
      b_size  <= eff_size;
      b_burst <= eff_burst;
      b_err   <= h_err;
      b_lower <= h_lower;
      b_upper <= h_lower + h_total;
    end else if (req_fire) begin
      b_addr <= b_next;
      b_cnt  <= b_cnt - 1'b1;
    end
  end

  // Tag FIFO and data buffer; tag count = inflight + buffered beats
  logic [TAG_W-1:0]  tag_mem [RDB_DEPTH];
  logic [DATA_W-1:0] dat_mem [RDB_DEPTH];
  logic [RD_AW:0]    tag_wr, tag_rd, dat_wr, dat_rd;
  logic              tag_full, tag_empty, dat_empty, r_fire;
  logic [ID_W-1:0]   t_id;
  logic              t_last, t_err;

  assign tag_empty = (tag_wr == tag_rd);
  assign tag_full  = (tag_wr[RD_AW] != tag_rd[RD_AW]) &&
                     (tag_wr[RD_AW-1:0] == tag_rd[RD_AW-1:0]);
  assign dat_empty = (dat_wr == dat_rd);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ar_empty) state_d = BURST;
      BURST:   if (req_fire && b_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a request is offered only while credit remains
  always_comb begin
    ar_pop        = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE:    ar_pop = !ar_empty;
      BURST:   mem_req_valid = !tag_full;
      default: ;
    endcase
  end

  assign req_fire     = mem_req_valid && mem_req_ready;
  assign mem_req_addr = b_addr;

  // Tag and data FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
      dat_wr <= '0;
      dat_rd <= '0;
    end else begin
      if (req_fire)      tag_wr <= tag_wr + 1'b1;
      if (mem_rsp_valid) dat_wr <= dat_wr + 1'b1;
      if (r_fire) begin
        tag_rd <= tag_rd + 1'b1;
        dat_rd <= dat_rd + 1'b1;
      end
    end
  end

  // Tag and data FIFO storage
  always_ff @(posedge clk) begin
    if (req_fire)      tag_mem[tag_wr[RD_AW-1:0]] <= {b_id, b_last, b_err};
    if (mem_rsp_valid) dat_mem[dat_wr[RD_AW-1:0]] <= mem_rsp_data;
  end

  assign {t_id, t_last, t_err} = tag_mem[tag_rd[RD_AW-1:0]];
  assign rvalid = !tag_empty && !dat_empty;
  assign r_fire = rvalid && rready;
  assign rid    = rvalid ? t_id : '0;
  assign rlast  = rvalid && t_last;
  assign rresp  = (rvalid && t_err) ? 2'b10 : 2'b00;
  assign rdata  = rvalid ? dat_mem[dat_rd[RD_AW-1:0]] : '0;

endmodule

// File: tb/tb_sal_axi_rd_resp.sv
// tb_sal_axi_rd_resp: directed and randomized bench for sal_axi_rd_resp with a
// queue-based reference of expected R beats and an in-order backend model.
module tb_sal_axi_rd_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  always #5 clk = ~clk;

  sal_axi_rd_resp dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rvalid(rvalid), .rready(rready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] idx;
    int          due;
  } pend_t;

  rbeat_t      exp_q[$];
  pend_t       pend_q[$];
  rbeat_t      mon_e;
  pend_t       drv_p;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int unsigned req_idx = 0;
  int unsigned exp_idx = 0;
  int          req_fires = 0;
  int          rready_mode = 0;
  int          mreq_mode = 0;
  logic [3:0]  hold_id;
  logic [63:0] hold_data;
  logic        hold_last;
  logic [3:0]  r_id, r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [31:0] r_addr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: expected R beats of one accepted burst, from the address rules
  task automatic model_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
    int      lg;
    int      b;
    bit      err = 0;
    longint  sz, total, base, a;
`ifdef SAL_AXI_RD_RESP_ERR_EN
    if (burst == 2'b11 || size > 3) begin
      err = 1; lg = 3; b = 1;
    end else begin
      lg = int'(size); b = int'(burst);
    end
`else
    lg = (size > 3) ? 3 : int'(size);
    b  = (burst == 2'b11) ? 1 : int'(burst);
`endif
    if (b == 2 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) b = 1;
    sz    = longint'(1) << lg;
    total = (longint'(len) + 1) * sz;
    base  = longint'(addr) - (longint'(addr) % total);
    for (int i = 0; i <= int'(len); i++) begin
      if (b == 0)      a = longint'(addr);
      else if (b == 2) a = base + ((longint'(addr) - base + i * sz) % total);
      else             a = longint'(addr) + i * sz;
      exp_q.push_back('{id, {32'(a), 32'(exp_idx)}, err ? 2'b10 : 2'b00, (i == int'(len))});
      exp_idx++;
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n = 0;
    bit ok = 0;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (arready) ok = 1;
      else n++;
    end
    chk("ar_accept", ok, 1);
    if (ok) model_burst(id, addr, len, size, burst);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_rvalid_idle"}, rvalid, 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe request and R handshakes between edges
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        pend_q.push_back('{mem_req_addr, req_idx, cyc + int'($urandom_range(1, 3))});
        req_idx++;
        req_fires++;
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rid", rid, mon_e.id);
          chk("rdata", rdata, mon_e.data);
          chk("rresp", rresp, mon_e.resp);
          chk("rlast", rlast, mon_e.last);
        end
      end
    end
  end

  // Backend responses (in order, >=1 cycle latency) and ready generation
  always @(posedge clk) begin
    #1;
    if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      drv_p = pend_q.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {drv_p.addr, drv_p.idx};
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    rready        = (rready_mode == 2) ? 1'($urandom_range(0, 1)) : (rready_mode == 1);
    mem_req_ready = (mreq_mode == 2) ? 1'($urandom_range(0, 1)) : (mreq_mode == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; rready = 1'b0; mem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", arready, 1);
    @(posedge clk); #1;

    // INCR burst with request latency check
    rready_mode = 1; mreq_mode = 1;
    send_ar(4'd3, 32'h100, 4'd3, 3'd3, 2'b01);
    @(negedge clk);
    chk("lat_cycle1", mem_req_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", mem_req_valid, 1);
    chk("lat_addr", mem_req_addr, 32'h100);
    @(posedge clk); #1;
    drain("incr");

    // WRAP and FIXED
    send_ar(4'd5, 32'h118, 4'd3, 3'd3, 2'b10);
    send_ar(4'd6, 32'h40, 4'd2, 3'd3, 2'b00);
    drain("wrap_fixed");

    // Reserved burst type and oversize beat
    send_ar(4'd7, 32'h200, 4'd1, 3'd3, 2'b11);
    send_ar(4'd8, 32'h300, 4'd2, 3'd5, 2'b01);
    drain("err");

    // Credit limit under R backpressure
    rready_mode = 0;
    req_fires = 0;
    send_ar(4'd9, 32'h1000, 4'd15, 3'd3, 2'b01);
    send_ar(4'd10, 32'h2000, 4'd3, 3'd3, 2'b01);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("bp_req_count", req_fires, 16);
    chk("bp_req_valid", mem_req_valid, 0);
    chk("bp_rvalid", rvalid, 1);
    hold_id = rid; hold_data = rdata; hold_last = rlast;
    repeat (3) @(negedge clk);
    chk("bp_hold_rid", rid, hold_id);
    chk("bp_hold_rdata", rdata, hold_data);
    chk("bp_hold_rlast", rlast, hold_last);
    @(posedge clk); #1;
    rready_mode = 1;
    drain("bp");

    // AR queue fill with backend stalled
    mreq_mode = 0;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) send_ar(4'(k), 32'h3000 + 32'(k) * 32'h100, 4'd1, 3'd3, 2'b01);
    @(negedge clk);
    chk("arq_full_arready", arready, 0);
    @(posedge clk); #1;
    mreq_mode = 1;
    drain("arq");

    // Randomized bursts with random ready patterns
    rready_mode = 2; mreq_mode = 2;
    for (int k = 0; k < 40; k++) begin
      r_id    = 4'($urandom);
      r_len   = 4'($urandom);
      r_size  = 3'($urandom);
      r_burst = 2'($urandom);
      r_addr  = $urandom;
      r_addr  = r_addr & ~((32'd1 << ((r_size > 3'd3) ? 3 : r_size)) - 32'd1);
      send_ar(r_id, r_addr, r_len, r_size, r_burst);
    end
    drain("rand");

    // Reset mid-burst
    rready_mode = 1; mreq_mode = 1;
    send_ar(4'd11, 32'h5000, 4'd15, 3'd3, 2'b01);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete(); pend_q.delete(); req_idx = 0; exp_idx = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_mem_req_valid", mem_req_valid, 0);
    @(posedge clk); #1;
    send_ar(4'd12, 32'h6000, 4'd2, 3'd2, 2'b01);
    drain("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
